// File: rtl/lab3_g29_p2_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: FSM states,
// requester count, selector width and the default word width.
package lab3_g29_p2_pkg;

  localparam int NREQ       = 16;
  localparam int SEL_W      = 4;
  localparam int DW_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/lab3_g29_p2_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found when scanning base, base+1, ... base+15 (mod 16).
module lab3_g29_p2_rr_pick
  import lab3_g29_p2_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // The 4-bit position counter wraps naturally, giving the mod-16 scan order
  always_comb begin
    found = 1'b0;
    idx   = base;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = base + SEL_W'(i);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/lab3_g29_p2_rr_arbiter_16.sv
// 16-requester round-robin arbiter with a registered output word, valid/ready
// handshake to downstream, and a one-cycle ack pulse back to the consumed requester.
module lab3_g29_p2_rr_arbiter_16
  import lab3_g29_p2_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREQ = lab3_g29_p2_pkg::NREQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack
);

  state_t           state, state_next;
  logic [SEL_W-1:0] ptr, ptr_next;
  logic [SEL_W-1:0] sel_next;
  logic [DW-1:0]    data_next;
  logic [NREQ-1:0]  ack_next;
  logic [SEL_W-1:0] pick_base;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [DW-1:0]    pick_word;

  // On a handshake the new base equals the pointer being written this edge,
  // so back-to-back grants skip the requester just served.
  assign pick_base = (state == HOLD) ? out_sel + SEL_W'(1) : ptr;
  assign pick_word = din[pick_idx*DW +: DW];

  lab3_g29_p2_rr_pick u_pick (
    .req   (req),
    .base  (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_valid = (state == HOLD);
  assign gnt       = out_valid ? (NREQ'(1) << out_sel) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
      ack      <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      out_data <= data_next;
      out_sel  <= sel_next;
      ack      <= ack_next;
    end
  end

  // While holding without ready nothing is re-sampled, so din/req changes are ignored
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = out_sel;
    data_next  = out_data;
    ack_next   = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = HOLD;
          sel_next   = pick_idx;
          data_next  = pick_word;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ptr_next = out_sel + SEL_W'(1);
          ack_next = NREQ'(1) << out_sel;
          if (pick_found) begin
            sel_next  = pick_idx;
            data_next = pick_word;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/lab3_g29_p2_rr_arbiter_16.md
LAB3_G29_P2_RR_ARBITER_16 -- requirements
Module: lab3_g29_p2_rr_arbiter_16

Interface
REQ-001 Parameter: DW, 4, data width of each requester word.
REQ-002 Parameter: NREQ, 16, number of requesters; fixed at 16, and other values are not supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: req  input  16  request vector; bit i = requester i has a valid word.
REQ-006 Port: din  input  16*DW  packed words; slice [i*DW +: DW] belongs to requester i.
REQ-007 Port: out_valid  output  1  out_data holds a granted word.
REQ-008 Port: out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-009 Port: out_data  output  DW  granted word, registered.
REQ-010 Port: out_sel  output  4  index of the granted requester, registered.
REQ-011 Port: gnt  output  16  one-hot of out_sel while out_valid=1; otherwise 0.
REQ-012 Port: ack  output  16  one-cycle one-hot pulse on the cycle after a handshake; identifies the consumed requester.

Function
REQ-013 FSM states: IDLE (no word held) and HOLD (word held, out_valid=1).
REQ-014 Round-robin pointer ptr (4 bits): search order is ptr, ptr+1, …, ptr+15, taken mod 16.
REQ-015 IDLE with req≠0 at edge N: capture the first set requester k in search order; out_data=din[k], out_sel=k, out_valid=1; state=HOLD at N+1 (one-cycle latency).
REQ-016 IDLE with req=0: stay IDLE; outputs hold their reset values except out_data/out_sel, which keep their last value.
REQ-017 HOLD with out_ready=0: out_data, out_sel and gnt stay stable and are not re-sampled, even if din or req changes.
REQ-018 HOLD with out_ready=1 is a handshake: ptr becomes out_sel+1, and 15 wraps to 0.
REQ-019 On handshake, ack bit out_sel pulses high for exactly the next cycle.
REQ-020 Handshake with req≠0: re-arbitrate in the same edge, using base out_sel+1, and stay in HOLD. Back-to-back throughput is 1 word/cycle with no bubble.
REQ-021 Handshake with req=0: go to IDLE and set out_valid=0.
REQ-022 The requester granted at the handshake is eligible at the same edge only if no other req bit is set, because it is last in search order.
REQ-023 A requester dropping req while in HOLD does not cancel the held word; the transfer completes.
REQ-024 out_ready while out_valid=0 is ignored.
REQ-025 Fairness: under continuous all-ones req with out_ready=1, the grant sequence is 0,1,…,15,0,…

Reset
REQ-026 When rst_n=0 at an edge: state=IDLE, ptr=0, out_valid=0, out_data=0, out_sel=0, gnt=0, ack=0.
REQ-027 Reset asserted in HOLD discards the held word and produces no ack.
REQ-028 The first arbitration after reset starts from requester 0.

Structure
REQ-029 A shared package lab3_g29_p2_pkg holds: the state enum typedef (IDLE, HOLD), NREQ=16, SEL_W=4 and the DW default.
REQ-030 The combinational picker is a sub-module, lab3_g29_p2_rr_pick.
  - Inputs: req[15:0], base[3:0].
  - Outputs: found, idx[3:0].
REQ-031 The top level contains only the FSM, ptr, the output registers and the din slice selection.

Verification
REQ-032 Reset test:
  - Stimulus: rst_n=0 for 2 cycles.
  - Response: all outputs 0; after release with req=0, out_valid stays 0.
REQ-033 Single request with backpressure:
  - Stimulus: req=16'h0020, din[5]=4'hA, out_ready=0 for 3 cycles, then out_ready=1.
  - Response: out_valid rises 1 cycle after req; out_sel=5 and out_data=A stay stable for 3 cycles; ack=16'h0020 one cycle after the handshake; ptr=6.
REQ-034 Wrap-around:
  - Stimulus: ptr=15 (after granting 14), req=16'h8001.
  - Response: grant 15, then 0.
REQ-035 Fairness sweep:
  - Stimulus: req=16'hFFFF, din[i]=i, out_ready=1 for 20 cycles.
  - Response: out_data sequence 0..15,0..3 with no bubbles.
REQ-036 Simultaneous events:
  - Stimulus: during HOLD on requester 3, req changes to 16'h0108 and din[3] changes, with the handshake in the same cycle.
  - Response: out_data unchanged until the handshake; next grant is 8, not 3.
REQ-037 Reset mid-operation:
  - Stimulus: rst_n=0 while in HOLD with out_ready=1.
  - Response: no ack; out_valid=0 next cycle; ptr=0.
